// File: rtl/pos_ram_reader.sv
// rtl/pos_ram_reader.sv - Reads positions from the position RAM and streams them as packed 128-bit words.
module pos_ram_reader #(
  parameter int WEIGHT     = 66,
  parameter int LOG_WEIGHT = 7,
  parameter int LOGW       = 16,
  parameter int OUT_WIDTH  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [LOG_WEIGHT:0]   count_i,
  output logic [LOG_WEIGHT-1:0] ram_addr_o,
  output logic                  ram_rd_o,
  input  logic [LOGW-1:0]       ram_q_i,
  output logic [OUT_WIDTH-1:0]  data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int LANES  = OUT_WIDTH / LOGW;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [2:0] {IDLE, READ, CAPT, HOLD, DONE} state_t;

  state_t              state;
  logic [LOG_WEIGHT:0] cnt;
  logic [LOG_WEIGHT:0] addr;       // next position to issue
  logic [LANE_W-1:0]   lane;       // lane of the read being issued
  logic                cap_valid;  // RAM data from last cycle's read is on ram_q_i
  logic [LANE_W-1:0]   cap_lane;

  logic [LOG_WEIGHT:0] clamp_cnt;
  logic [LOG_WEIGHT:0] addr_nxt;
  logic                word_end;

  assign clamp_cnt = (count_i > (LOG_WEIGHT+1)'(WEIGHT)) ? (LOG_WEIGHT+1)'(WEIGHT) : count_i;
  assign addr_nxt  = addr + 1'b1;
  assign word_end  = (lane == LANE_W'(LANES - 1)) || (addr_nxt == cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr       <= '0;
      lane       <= '0;
      cap_valid  <= 1'b0;
      cap_lane   <= '0;
      ram_addr_o <= '0;
      ram_rd_o   <= 1'b0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      cap_valid <= ram_rd_o;
      cap_lane  <= lane;

      case (state)
        IDLE: begin
          if (start_i) begin
            cnt    <= clamp_cnt;
            addr   <= '0;
            lane   <= '0;
            data_o <= '0;
            busy_o <= 1'b1;
            if (clamp_cnt != '0) begin
              state      <= READ;
              ram_rd_o   <= 1'b1;
              ram_addr_o <= '0;
            end else begin
              state <= DONE;
            end
          end
        end

        READ: begin
          addr <= addr_nxt;
          if (word_end) begin
            state    <= CAPT;
            ram_rd_o <= 1'b0;
            lane     <= '0;
          end else begin
            ram_addr_o <= addr_nxt[LOG_WEIGHT-1:0];
            lane       <= lane + 1'b1;
          end
        end

        CAPT: begin
          state   <= HOLD;
          valid_o <= 1'b1;
          last_o  <= (addr == cnt);
        end

        HOLD: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            data_o  <= '0;
            if (addr == cnt) begin
              state  <= DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              state      <= READ;
              ram_rd_o   <= 1'b1;
              ram_addr_o <= addr[LOG_WEIGHT-1:0];
            end
          end
        end

        DONE: begin
          // Zero-count starts arrive here with done_o still low and pulse one cycle later.
          if (done_o) begin
            done_o <= 1'b0;
            state  <= IDLE;
          end else begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase

      if (cap_valid) data_o[cap_lane*LOGW +: LOGW] <= ram_q_i;
    end
  end

endmodule
